// File: rtl/ram_port_arbiter.sv
// Shares one word-wide RAM port between NREQ requesters using two-class round-robin
// arbitration with a starvation bound for the low class and optional grant locking.
module ram_port_arbiter #(
  parameter int              NREQ       = 4,
  parameter logic [NREQ-1:0] HIPRI_MASK = 4'b1100,
  parameter int              HI_STREAK  = 4,
  parameter int              MAX_LOCK   = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NREQ-1:0]    req_ren,
  input  logic [NREQ-1:0]    req_wen,
  input  logic [NREQ-1:0]    req_lock,
  input  logic [NREQ*32-1:0] req_addr,
  input  logic [NREQ*32-1:0] req_store,
  output logic [NREQ-1:0]    req_wait,
  output logic [31:0]        req_load,
  output logic [NREQ-1:0]    req_err,
  output logic [NREQ-1:0]    gnt,
  output logic               ramREN,
  output logic               ramWEN,
  output logic [31:0]        ramaddr,
  output logic [31:0]        ramstore,
  input  logic [31:0]        ramload,
  input  logic [1:0]         ramstate
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = $clog2(HI_STREAK + 1);
  localparam int LW = $clog2(MAX_LOCK) + 1;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t          state;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   rr_hi;
  logic [IW-1:0]   rr_lo;
  logic [SW-1:0]   streak;
  logic [LW-1:0]   lock_cnt;

  ramstate_t       rs;
  logic [NREQ-1:0] pending;
  logic [NREQ-1:0] hi_pend;
  logic [NREQ-1:0] lo_pend;
  logic            use_lo;
  logic [IW-1:0]   winner;
  logic            owner_pend;
  logic            owner_hi;

  // First candidate at or after ptr, wrapping modulo NREQ.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] cand, input logic [IW-1:0] ptr);
    logic [IW-1:0] sel;
    int            idx;
    sel = ptr;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (cand[IW'(idx)]) sel = IW'(idx);
    end
    return sel;
  endfunction

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v >= SW'(HI_STREAK)) ? v : v + SW'(1);
  endfunction

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] g);
    return (int'(g) == NREQ - 1) ? '0 : g + IW'(1);
  endfunction

  assign rs         = ramstate_t'(ramstate);
  assign pending    = req_ren | req_wen;
  assign hi_pend    = pending & HIPRI_MASK;
  assign lo_pend    = pending & ~HIPRI_MASK;
  assign use_lo     = (|lo_pend) && (!(|hi_pend) || (streak == SW'(HI_STREAK)));
  assign winner     = use_lo ? rr_pick(lo_pend, rr_lo) : rr_pick(hi_pend, rr_hi);
  assign owner_pend = pending[owner];
  assign owner_hi   = HIPRI_MASK[owner];
  assign req_load   = ramload;

  // RAM side is driven straight from the owner's inputs so no cycle is lost per word.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    req_wait = '1;
    req_err  = '0;
    if (state == ACTIVE) begin
      ramaddr  = req_addr[int'(owner)*32 +: 32];
      ramstore = req_store[int'(owner)*32 +: 32];
      ramWEN   = req_wen[owner];
      ramREN   = req_ren[owner] & ~req_wen[owner];
      if (owner_pend && rs == ACCESS) req_wait[owner] = 1'b0;
      if (owner_pend && rs == ERROR)  req_err[owner]  = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      gnt      <= '0;
      owner    <= '0;
      rr_hi    <= '0;
      rr_lo    <= '0;
      streak   <= '0;
      lock_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|pending) begin
            gnt   <= NREQ'(1) << winner;
            owner <= winner;
            state <= ACTIVE;
          end
        end
        ACTIVE: begin
          // An owner that withdraws is released without touching fairness state.
          if (!owner_pend) begin
            state    <= IDLE;
            gnt      <= '0;
            lock_cnt <= '0;
          end else if (rs == ACCESS && req_lock[owner] && lock_cnt < LW'(MAX_LOCK - 1)) begin
            lock_cnt <= lock_cnt + LW'(1);
          end else if (rs == ACCESS || rs == ERROR) begin
            state    <= IDLE;
            gnt      <= '0;
            lock_cnt <= '0;
            if (owner_hi) begin
              rr_hi  <= next_ptr(owner);
              streak <= (|lo_pend) ? sat_inc(streak) : '0;
            end else begin
              rr_lo  <= next_ptr(owner);
              streak <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: reset checks, a vector table from idle, directed
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_ram_port_arbiter;

  localparam int          NREQ      = 4;
  localparam logic [3:0]  HIPRI     = 4'b1100;
  localparam int          HI_STREAK = 4;
  localparam int          MAX_LOCK  = 8;
  localparam logic [1:0]  FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic               CLK = 1'b0;
  logic               RST;
  logic [NREQ-1:0]    req_ren, req_wen, req_lock;
  logic [NREQ*32-1:0] req_addr, req_store;
  logic [NREQ-1:0]    req_wait, req_err, gnt;
  logic [31:0]        req_load, ramaddr, ramstore, ramload;
  logic               ramREN, ramWEN;
  logic [1:0]         ramstate;

  ram_port_arbiter #(.NREQ(NREQ), .HIPRI_MASK(HIPRI), .HI_STREAK(HI_STREAK), .MAX_LOCK(MAX_LOCK)) dut (
    .CLK(CLK), .RST(RST), .req_ren(req_ren), .req_wen(req_wen), .req_lock(req_lock),
    .req_addr(req_addr), .req_store(req_store), .req_wait(req_wait), .req_load(req_load),
    .req_err(req_err), .gnt(gnt), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;
  bit model_on;

  // Model state: owner index (-1 = idle), per-class pointers, streak, words under lock.
  int m_owner, m_rr_hi, m_rr_lo, m_streak, m_lock;

  typedef struct {
    logic [3:0]  ren;
    logic [3:0]  wen;
    logic [3:0]  exp_gnt;
    logic        exp_ren;
    logic        exp_wen;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t tbl[8];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit pend(input int i);
    return req_ren[i] | req_wen[i];
  endfunction

  function automatic bit is_hi(input int i);
    return HIPRI[i];
  endfunction

  task automatic model_reset();
    m_owner = -1; m_rr_hi = 0; m_rr_lo = 0; m_streak = 0; m_lock = 0;
  endtask

  // Pick the pending requester of the chosen class closest (cyclically) after its pointer.
  function automatic int choose();
    bit hi_any = 0, lo_any = 0, want_hi;
    int best = -1, best_d = NREQ, d, base;
    for (int i = 0; i < NREQ; i++)
      if (pend(i)) begin
        if (is_hi(i)) hi_any = 1; else lo_any = 1;
      end
    want_hi = hi_any && !(lo_any && m_streak == HI_STREAK);
    base = want_hi ? m_rr_hi : m_rr_lo;
    for (int i = 0; i < NREQ; i++)
      if (pend(i) && is_hi(i) == want_hi) begin
        d = (i - base + NREQ) % NREQ;
        if (d < best_d) begin best = i; best_d = d; end
      end
    return best;
  endfunction

  task automatic model_check();
    logic [3:0] eg = '0, ew = '1, ee = '0;
    logic er = 0, ewn = 0;
    logic [31:0] ea = '0, es = '0;
    if (m_owner >= 0) begin
      eg  = 4'(1 << m_owner);
      ewn = req_wen[m_owner];
      er  = req_ren[m_owner] & ~req_wen[m_owner];
      ea  = req_addr[m_owner*32 +: 32];
      es  = req_store[m_owner*32 +: 32];
      if (pend(m_owner) && ramstate == ACCESS) ew[m_owner] = 1'b0;
      if (pend(m_owner) && ramstate == ERROR)  ee[m_owner] = 1'b1;
    end
    cmp("m_gnt", 32'(gnt), 32'(eg));
    cmp("m_wait", 32'(req_wait), 32'(ew));
    cmp("m_err", 32'(req_err), 32'(ee));
    cmp("m_ren", 32'(ramREN), 32'(er));
    cmp("m_wen", 32'(ramWEN), 32'(ewn));
    cmp("m_addr", ramaddr, ea);
    cmp("m_store", ramstore, es);
    cmp("m_load", req_load, ramload);
  endtask

  task automatic model_advance();
    bit lo_any = 0;
    if (RST) begin model_reset(); return; end
    for (int i = 0; i < NREQ; i++) if (pend(i) && !is_hi(i)) lo_any = 1;
    if (m_owner < 0) begin
      if (req_ren != 0 || req_wen != 0) m_owner = choose();
    end else if (!pend(m_owner)) begin
      m_owner = -1; m_lock = 0;
    end else if (ramstate == ACCESS && req_lock[m_owner] && m_lock < MAX_LOCK - 1) begin
      m_lock++;
    end else if (ramstate == ACCESS || ramstate == ERROR) begin
      if (is_hi(m_owner)) begin
        m_streak = lo_any ? ((m_streak < HI_STREAK) ? m_streak + 1 : HI_STREAK) : 0;
        m_rr_hi  = (m_owner + 1) % NREQ;
      end else begin
        m_streak = 0;
        m_rr_lo  = (m_owner + 1) % NREQ;
      end
      m_owner = -1; m_lock = 0;
    end
  endtask

  // Inputs change at posedge+1; the model is checked at negedge and stepped at posedge.
  task automatic tick();
    @(negedge CLK);
    if (model_on) model_check();
    @(posedge CLK);
    model_advance();
    #1;
  endtask

  task automatic set_addr(input int i, input logic [31:0] a);
    req_addr[i*32 +: 32] = a;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [3:0] t2[8];
    logic [3:0] t3[12];
    t2 = '{4'h4, 4'h0, 4'h8, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0};
    t3 = '{4'h4, 4'h0, 4'h8, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0, 4'h4, 4'h0};
    tbl[0] = '{4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b0, 32'h100};
    tbl[1] = '{4'b0110, 4'b0000, 4'b0100, 1'b1, 1'b0, 32'h120};
    tbl[2] = '{4'b1010, 4'b0000, 4'b1000, 1'b1, 1'b0, 32'h130};
    tbl[3] = '{4'b0011, 4'b0000, 4'b0001, 1'b1, 1'b0, 32'h100};
    tbl[4] = '{4'b0010, 4'b0000, 4'b0010, 1'b1, 1'b0, 32'h110};
    tbl[5] = '{4'b0000, 4'b1001, 4'b1000, 1'b0, 1'b1, 32'h130};
    tbl[6] = '{4'b1100, 4'b0100, 4'b0100, 1'b0, 1'b1, 32'h120};
    tbl[7] = '{4'b1111, 4'b1111, 4'b0100, 1'b0, 1'b1, 32'h120};

    // Reset with every requester asking: nothing may leak to the RAM.
    RST = 1'b1;
    req_ren = 4'b1111; req_wen = 4'b0101; req_lock = '0; ramstate = ACCESS; ramload = 32'h1234_5678;
    for (int i = 0; i < NREQ; i++) begin
      set_addr(i, 32'h100 + 32'(i) * 32'h10);
      req_store[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    end
    model_reset();
    model_on = 1'b1;
    repeat (2) tick();
    cmp("rst_gnt", 32'(gnt), 32'h0);
    cmp("rst_wait", 32'(req_wait), 32'hF);
    cmp("rst_err", 32'(req_err), 32'h0);
    cmp("rst_ren", 32'(ramREN), 32'h0);
    cmp("rst_wen", 32'(ramWEN), 32'h0);
    cmp("rst_addr", ramaddr, 32'h0);
    cmp("rst_store", ramstore, 32'h0);
    RST = 1'b0; req_ren = '0; req_wen = '0; ramstate = BUSY;
    tick();

    // Vector table: grant from idle, then withdraw so pointers stay at reset values.
    for (int v = 0; v < 8; v++) begin
      req_ren = tbl[v].ren; req_wen = tbl[v].wen; ramstate = BUSY;
      tick();
      #1;
      cmp($sformatf("tbl%0d_gnt", v), 32'(gnt), 32'(tbl[v].exp_gnt));
      cmp($sformatf("tbl%0d_ren", v), 32'(ramREN), 32'(tbl[v].exp_ren));
      cmp($sformatf("tbl%0d_wen", v), 32'(ramWEN), 32'(tbl[v].exp_wen));
      cmp($sformatf("tbl%0d_addr", v), ramaddr, tbl[v].exp_addr);
      cmp($sformatf("tbl%0d_wait", v), 32'(req_wait), 32'hF);
      req_ren = '0; req_wen = '0;
      #1;
      cmp($sformatf("tbl%0d_abort_en", v), 32'({ramREN, ramWEN}), 32'h0);
      tick();
      cmp($sformatf("tbl%0d_idle", v), 32'(gnt), 32'h0);
    end

    // Single read with two BUSY cycles.
    set_addr(0, 32'h40);
    req_ren = 4'b0001; ramstate = FREE;
    tick();
    #1;
    cmp("t1_gnt", 32'(gnt), 32'h1);
    cmp("t1_addr", ramaddr, 32'h40);
    tick(); ramstate = BUSY;
    tick();
    tick(); ramstate = ACCESS; ramload = 32'hDEAD_BEEF;
    #1;
    cmp("t1_wait", 32'(req_wait), 32'hE);
    cmp("t1_load", req_load, 32'hDEAD_BEEF);
    tick();
    cmp("t1_idle", 32'(gnt), 32'h0);
    req_ren = '0;

    // Two high-class requesters alternate with an idle bubble between owners.
    req_ren = 4'b1100; ramstate = ACCESS;
    for (int k = 0; k < 8; k++) begin
      tick();
      cmp($sformatf("t2_gnt%0d", k), 32'(gnt), 32'(t2[k]));
    end

    // Low requester 0 gets in after HI_STREAK high grants.
    req_ren = 4'b1101;
    for (int k = 0; k < 12; k++) begin
      tick();
      cmp($sformatf("t3_gnt%0d", k), 32'(gnt), 32'(t3[k]));
    end

    // Locked writeback: exactly MAX_LOCK back-to-back words, then the next requester.
    req_ren = 4'b0100; req_wen = 4'b1000; req_lock = 4'b1000; ramstate = ACCESS;
    for (int k = 0; k < MAX_LOCK; k++) begin
      tick();
      cmp($sformatf("t4_gnt%0d", k), 32'(gnt), 32'h8);
      cmp($sformatf("t4_wait%0d", k), 32'(req_wait), 32'h7);
    end
    tick();
    cmp("t4_release", 32'(gnt), 32'h0);
    tick();
    cmp("t4_next", 32'(gnt), 32'h4);
    req_ren = '0; req_wen = '0; req_lock = '0;
    tick();

    // Abort leaves the pointer alone; error pulses req_err and advances it.
    ramstate = BUSY; req_ren = 4'b0010;
    tick();
    cmp("t5_gnt", 32'(gnt), 32'h2);
    req_ren = '0;
    #1;
    cmp("t5_abort_en", 32'({ramREN, ramWEN}), 32'h0);
    cmp("t5_abort_wait", 32'(req_wait), 32'hF);
    tick();
    cmp("t5_abort_idle", 32'(gnt), 32'h0);
    req_ren = 4'b0011;
    tick();
    cmp("t5_rr_kept", 32'(gnt), 32'h2);
    ramstate = ERROR;
    #1;
    cmp("t5_err", 32'(req_err), 32'h2);
    cmp("t5_err_wait", 32'(req_wait), 32'hF);
    tick();
    cmp("t5_err_gone", 32'(req_err), 32'h0);
    cmp("t5_err_idle", 32'(gnt), 32'h0);
    tick();
    ramstate = BUSY;
    cmp("t5_rr_moved", 32'(gnt), 32'h1);

    // Asynchronous reset in the middle of a write.
    req_ren = '0; req_wen = 4'b0001;
    #1;
    cmp("t6_wen_before", 32'(ramWEN), 32'h1);
    model_on = 1'b0;
    #1 RST = 1'b1;
    #1;
    cmp("t6_wen_async", 32'(ramWEN), 32'h0);
    cmp("t6_gnt_async", 32'(gnt), 32'h0);
    tick();
    #2 RST = 1'b0;
    #1;
    cmp("t6_idle", 32'(gnt), 32'h0);
    model_reset();
    model_on = 1'b1;
    tick();
    cmp("t6_regrant", 32'(gnt), 32'h1);

    // Randomized traffic checked every cycle by the model.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) != 0) begin
        req_ren = 4'($urandom_range(0, 15));
        req_wen = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      end
      req_lock = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 7))
        0, 1:    ramstate = BUSY;
        2:       ramstate = FREE;
        3:       ramstate = ERROR;
        default: ramstate = ACCESS;
      endcase
      for (int i = 0; i < NREQ; i++) begin
        set_addr(i, $urandom);
        req_store[i*32 +: 32] = $urandom;
      end
      ramload = $urandom;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
